// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache read port between N_REQ pixel units.
// Each grant runs lookup -> (fill -> retry lookup)* -> one registered response.
module cache_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      cache_rd_en,
    output logic [ADDR_W-1:0]         cache_addr,
    input  logic                      cache_hit,
    input  logic [DATA_W-1:0]         cache_rdata,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_done,
    output logic                      busy,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                cache_rd_en_q, cache_rd_en_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    logic                found;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   sel_addr;

    // First requesting index at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(rr_ptr_q) + i >= N_REQ) cand = PTR_W'(int'(rr_ptr_q) + i - N_REQ);
            else                             cand = PTR_W'(int'(rr_ptr_q) + i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        sel_addr = req_addr[sel_idx*ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        cur_addr_d    = cur_addr_q;
        cache_rd_en_d = 1'b0;
        cache_addr_d  = cache_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d        = sel_idx;
                    cur_addr_d    = sel_addr;
                    cache_rd_en_d = 1'b1;
                    cache_addr_d  = sel_addr;
                    state_d       = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_data_d          = cache_rdata;
                    hit_cnt_d           = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                    state_d             = RESP;
                end else begin
                    miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = cur_addr_q;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_done) begin
                    mem_req_d     = 1'b0;
                    cache_rd_en_d = 1'b1;
                    cache_addr_d  = cur_addr_q;
                    state_d       = LOOKUP;
                end
            end
            RESP: begin
                rr_ptr_d = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gidx_q        <= '0;
            cur_addr_q    <= '0;
            cache_rd_en_q <= 1'b0;
            cache_addr_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gidx_q        <= gidx_d;
            cur_addr_q    <= cur_addr_d;
            cache_rd_en_q <= cache_rd_en_d;
            cache_addr_q  <= cache_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign cache_rd_en = cache_rd_en_q;
    assign cache_addr  = cache_addr_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
endmodule
